axi_bus_arbiter: RTL

- Shares the single AXI3 master port between two requesters: the instruction-fetch port (read-only) and the data port (read/write).
- Each requester uses an SRAM-like req/addr_ok/data_ok handshake.
- Single-beat transfers only. One outstanding transaction at a time. Fixed priority to data.
- Sits inside widsnoy_cpu between the pipeline and the io_axi_* ports.

---
 rtl/axi_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/axi_bus_arbiter.sv
// axi_bus_arbiter: shares one AXI3 master between the fetch and data ports, single-beat, one outstanding, data wins
module axi_bus_arbiter #(
    parameter logic [3:0] INST_ID = 4'd0,
    parameter logic [3:0] DATA_ID = 4'd1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP} state_t;
    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] inst_rdata_q, inst_rdata_d, data_rdata_q, data_rdata_d;
    logic [1:0]  size_q, size_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic        inst_ok_q, inst_ok_d, data_ok_q, data_ok_d;
    logic        accept, rd_done;
    logic        unused_rid;

    assign unused_rid = ^rid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = data_addr_ok ? (data_wr ? WR : RD_ADDR) : inst_addr_ok ? RD_ADDR : IDLE;
            RD_ADDR: state_d = arready ? RD_DATA : RD_ADDR;
            RD_DATA: state_d = rvalid ? IDLE : RD_DATA;
            WR:      state_d = ((aw_done_q | awready) & (w_done_q | wready)) ? WR_RESP : WR;
            WR_RESP: state_d = bvalid ? IDLE : WR_RESP;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, per-channel write progress and per-owner read data
    always_comb begin
        accept       = data_addr_ok | inst_addr_ok;
        owner_d      = accept ? data_addr_ok : owner_q;
        addr_d       = accept ? (data_addr_ok ? data_addr : inst_addr) : addr_q;
        size_d       = accept ? ((data_addr_ok && data_size != 2'd3) ? data_size : 2'd2) : size_q;
        wstrb_d      = data_addr_ok ? data_wstrb : wstrb_q;
        wdata_d      = data_addr_ok ? data_wdata : wdata_q;
        aw_done_d    = state_q == WR && (aw_done_q | awready);
        w_done_d     = state_q == WR && (w_done_q | wready);
        rd_done      = state_q == RD_DATA && rvalid;
        inst_rdata_d = (rd_done && !owner_q) ? rdata : inst_rdata_q;
        data_rdata_d = (rd_done && owner_q) ? rdata : data_rdata_q;
        inst_ok_d    = rd_done && !owner_q;
        data_ok_d    = (rd_done && owner_q) || (state_q == WR_RESP && bvalid);
    end

    always_comb begin
        data_addr_ok = state_q == IDLE && !reset && data_req;
        inst_addr_ok = state_q == IDLE && !reset && inst_req && !data_req;
        inst_data_ok = inst_ok_q;
        data_data_ok = data_ok_q;
        inst_rdata   = inst_rdata_q;
        data_rdata   = data_rdata_q;
        arid         = owner_q ? DATA_ID : INST_ID;
        araddr       = addr_q;
        arsize       = {1'b0, size_q};
        arvalid      = state_q == RD_ADDR;
        rready       = state_q == RD_DATA;
        awaddr       = addr_q;
        awsize       = {1'b0, size_q};
        awvalid      = state_q == WR && !aw_done_q;
        wdata        = wdata_q;
        wstrb        = wstrb_q;
        wvalid       = state_q == WR && !w_done_q;
        bready       = state_q == WR_RESP;
    end
endmodule
